// File: rtl/bus_cycle_terminator_if.sv
// Bus-cycle signals between the address decode / CPU pads (master) and the
// cycle terminator (slave). port_width: 00=NULL, 01=BYTE, 10=WORD, 11=LONG.
interface bus_cycle_terminator_if;
  logic       as;
  logic       function_normal_selected;
  logic       function_int_ack_selected;
  logic       function_fpu_selected;
  logic       device_valid;
  logic [1:0] port_width;
  logic [3:0] wait_states;
  logic [1:0] dsack;
  logic       berr;
  logic       avec;
  logic       vector_fetched;

  modport master (
    output as, function_normal_selected, function_int_ack_selected,
           function_fpu_selected, device_valid, port_width, wait_states,
    input  dsack, berr, avec, vector_fetched
  );

  modport slave (
    input  as, function_normal_selected, function_int_ack_selected,
           function_fpu_selected, device_valid, port_width, wait_states,
    output dsack, berr, avec, vector_fetched
  );
endinterface

// File: rtl/bus_cycle_terminator.sv
// Terminates each 68030 bus cycle with DSACK, AVEC or BERR, and raises the
// sticky vector_fetched flag once the reset vectors have been read.
module bus_cycle_terminator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned VECTOR_CYCLES  = 4
) (
  input logic                   clock,
  input logic                   reset,
  bus_cycle_terminator_if.slave bus
);

  localparam logic [1:0] PW_NULL      = 2'b00;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);
  localparam logic [2:0] VECTOR_LAST  = 3'(VECTOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_AVEC, S_EXT, S_BERR
  } state_t;

  state_t     state_q;
  logic [3:0] wait_q;
  logic [1:0] width_q;
  logic [7:0] tmo_q;
  logic [2:0] vcnt_q;
  logic       armed_q;
  logic       vf_q;
  logic [1:0] dsack_q;
  logic       berr_q;
  logic       avec_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      width_q <= '0;
      tmo_q   <= '0;
      vcnt_q  <= '0;
      armed_q <= 1'b0;
      vf_q    <= 1'b0;
      dsack_q <= '0;
      berr_q  <= 1'b0;
      avec_q  <= 1'b0;
    end else if (!bus.as) begin
      // as low ends any cycle; only completed ACK cycles count toward the vectors
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      dsack_q <= '0;
      berr_q  <= 1'b0;
      avec_q  <= 1'b0;
      if (state_q == S_ACK && !vf_q) begin
        if (vcnt_q == VECTOR_LAST) begin
          vf_q <= 1'b1;
        end else begin
          vcnt_q <= vcnt_q + 3'd1;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            tmo_q <= '0;
            if (bus.function_normal_selected) begin
              if (bus.device_valid && bus.port_width != PW_NULL) begin
                state_q <= S_WAIT;
                wait_q  <= bus.wait_states;
                width_q <= bus.port_width;
              end else begin
                state_q <= S_BERR;
                berr_q  <= 1'b1;
              end
            end else if (bus.function_int_ack_selected) begin
              state_q <= S_AVEC;
              avec_q  <= 1'b1;
            end else if (bus.function_fpu_selected) begin
              state_q <= S_EXT;
            end else begin
              state_q <= S_BERR;
              berr_q  <= 1'b1;
            end
          end
        end
        // ACK is tested before the timeout so it wins a same-edge tie
        S_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= S_ACK;
            dsack_q <= width_q;
          end else if (tmo_q == TIMEOUT_LAST) begin
            state_q <= S_BERR;
            berr_q  <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
            tmo_q  <= tmo_q + 8'd1;
          end
        end
        S_EXT: begin
          if (tmo_q == TIMEOUT_LAST) begin
            state_q <= S_BERR;
            berr_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_ACK, S_AVEC, S_BERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dsack          = dsack_q;
  assign bus.berr           = berr_q;
  assign bus.avec           = avec_q;
  assign bus.vector_fetched = vf_q;

endmodule

// File: doc/bus_cycle_terminator.md
# bus_cycle_terminator

Responder side of the MAXI030 bus cycle: takes the per-cycle function/device/port-width decode and terminates each 68030 cycle. Generates DSACK after a per-cycle wait count, AVEC for interrupt acknowledge, and BERR for unmapped addresses or timeouts. Also produces the sticky `vector_fetched` flag that switches the decoder out of the reset-time ROM overlay. Sits between the address decode and the CPU control pads; pad polarity inversion is done outside this block.

## Interface
- `TIMEOUT_CYCLES`, 255: clocks with `as` high and no termination before BERR; 8-bit compare.
- `VECTOR_CYCLES`, 4: acknowledged cycles after reset before `vector_fetched` sets (SSP + PC as 16-bit ROM words).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `as`  in  1  address strobe, active-high internal (synchronised upstream).
- `function_normal_selected`  in  1  normal memory/IO cycle.
- `function_int_ack_selected`  in  1  interrupt acknowledge cycle.
- `function_fpu_selected`  in  1  coprocessor cycle; FPU terminates it itself.
- `device_valid`  in  1  OR of all device selects.
- `port_width`  in  `PORT_WIDTH_WIDTH`  `PORT_WIDTH_BYTE/WORD/LONG/NULL` from addr_decode.vh.
- `wait_states`  in  4  wait clocks for this cycle (0–15).
- `dsack`  out  2  {DSACK1, DSACK0}, active-high.
- `berr`  out  1  bus error, active-high.
- `avec`  out  1  autovector request, active-high.
- `vector_fetched`  out  1  sticky; 0 until the reset vectors have been read.

## Operation
- States: IDLE, WAIT, ACK, AVEC, EXT, BERR.
- IDLE, `as` high (and armed), decided on that edge ("edge 0"):
  - normal, `device_valid`=1, `port_width`≠NULL → WAIT. Counter=`wait_states`, width latched.
  - normal, `device_valid`=0 or `port_width`=NULL → BERR.
  - int_ack → AVEC.
  - fpu → EXT.
  - none of the function selects → BERR.
- WAIT: counter==0 → ACK, else decrement.
- ACK: `dsack` driven from the latched width: BYTE=2'b01, WORD=2'b10, LONG=2'b11. Held until `as` low.
- AVEC: `avec`=1 until `as` low. BERR: `berr`=1 until `as` low. EXT: no outputs driven; only the timeout runs.
- Timeout counter: cleared at edge 0, increments each clock in WAIT/EXT. When it reaches `TIMEOUT_CYCLES` → BERR.
  - If ACK and timeout fall on the same edge, ACK wins.
- `as` sampled low in any state → IDLE on that edge; all outputs 0 after it.
- Armed flag: cleared by reset; set when `as` is sampled low. IDLE ignores `as` while not armed, so a cycle in flight across reset is never acknowledged.
- `vector_fetched`: 3-bit count of ACK→IDLE transitions while the flag is 0.
  - Flag sets on the edge where the `VECTOR_CYCLES`th acknowledged cycle returns to IDLE, so decode never changes mid-cycle.
  - Once set, it stays set until reset.
  - BERR, AVEC and EXT cycles do not count.

## Timing
- Reset values: state IDLE; `dsack`=0, `berr`=0, `avec`=0, `vector_fetched`=0; counters 0; armed=0.
- All outputs are registered.
- `dsack` rises on edge N+1, where N=`wait_states` sampled at edge 0. N=0 gives `dsack` one clock after `as` is first sampled.
- `berr` (decode error) and `avec` rise on edge 0.
- Timeout `berr` rises on edge `TIMEOUT_CYCLES`+1.
- Deassert: outputs fall on the first edge `as` is sampled low.
- Back-to-back cycles: `as` must be sampled low for at least one edge; a new cycle may start on the next edge.
- `wait_states`, `port_width` and the selects are sampled only at edge 0; changes later in the cycle are ignored.
- Reset asserted mid-cycle: outputs 0 on that edge. The cycle is not resumed; the CPU's own reset covers it.

## Test plan
- Reset, then four WORD ROM cycles with `wait_states`=2:
  - each `dsack`=2'b10 from edge 3 until `as` falls;
  - `vector_fetched`=0 through cycle 4's ACK, 1 on the edge cycle 4 returns to IDLE;
  - a fifth cycle leaves it at 1.
- Width and wait mapping: BYTE with `wait_states`=0 → `dsack`=2'b01 on edge 1. LONG with `wait_states`=15 → `dsack`=2'b11 on edge 16.
- Normal cycle with `device_valid`=0 → `berr`=1 from edge 0, `dsack`=0 throughout. Int_ack cycle → `avec`=1 from edge 0.
- FPU cycle, `as` held 300 clocks with `TIMEOUT_CYCLES`=255 → `berr` rises on edge 256 and stays until `as` falls. A WAIT cycle with `wait_states`=15 and `TIMEOUT_CYCLES`=15 → ACK wins, `dsack` asserts and `berr` stays 0.
- `as` high through reset release, held 10 clocks → no `dsack`/`berr`/`avec`. `as` low, then a new cycle → acknowledged normally.
- `as` dropped during WAIT (counter=5) → IDLE next edge, no `dsack` pulse; not counted toward `vector_fetched`.
